// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port among 4 write-back
// requesters (0 ALU, 1 load, 2 link, 3 HI/LO) and holds each grant for WB_CYCLES.
// Ports: clk, rst_n (sync, active-low); req[3:0] level requests held until ack;
//   mux_sel[1:0] address/data mux select; grant[3:0] one-hot owner;
//   reg_we write enable; ack[3:0] pulse on the owner's last write cycle;
//   stall = any request not currently granted.
// Config: define WB_RR_EN for round-robin arbitration (default fixed priority).
module regfile_wb_arbiter #(
  parameter int WB_CYCLES = 1,
  parameter int CNT_W     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [1:0] mux_sel,
  output logic [3:0] grant,
  output logic       reg_we,
  output logic [3:0] ack,
  output logic       stall
);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t           state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic [3:0]       grantNext;
  logic [1:0]       selNext;
  logic             weNext;
  logic [3:0]       cand;
  logic [1:0]       win;
  logic             winValid;
  logic             lastCycle;

  function automatic logic [1:0] pickLow(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    priority case (1'b1)
      v[0]:    idx = 2'd0;
      v[1]:    idx = 2'd1;
      v[2]:    idx = 2'd2;
      v[3]:    idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  assign lastCycle = (state == WRITE) && (cnt == '0);

  // The finishing owner is masked so it cannot win its own slot twice.
  always_comb begin
    cand = '0;
    if (state == IDLE)
      cand = req;
    else if (lastCycle)
      cand = req & ~grant;
  end

  assign winValid = |cand;

`ifdef WB_RR_EN
  logic [1:0] rrPtr;
  logic [7:0] candDbl;
  logic [3:0] candRot;

  // Rotate so bit 0 of candRot is requester rrPtr; the search then wraps 3->0.
  assign candDbl = {cand, cand};
  assign candRot = candDbl[rrPtr +: 4];
  assign win     = pickLow(candRot) + rrPtr;

  always_ff @(posedge clk) begin
    if (!rst_n)
      rrPtr <= 2'd0;
    else if (lastCycle)
      rrPtr <= mux_sel + 2'd1;
  end
`else
  assign win = pickLow(cand);
`endif

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    grantNext = grant;
    selNext   = mux_sel;
    weNext    = reg_we;
    unique case (state)
      IDLE: begin
        if (winValid) begin
          stateNext = WRITE;
          grantNext = 4'b0001 << win;
          selNext   = win;
          weNext    = 1'b1;
          cntNext   = CNT_W'(WB_CYCLES - 1);
        end
      end
      WRITE: begin
        if (cnt != '0) begin
          cntNext = cnt - CNT_W'(1);
        end else if (winValid) begin
          grantNext = 4'b0001 << win;
          selNext   = win;
          weNext    = 1'b1;
          cntNext   = CNT_W'(WB_CYCLES - 1);
        end else begin
          stateNext = IDLE;
          grantNext = '0;
          selNext   = 2'd0;
          weNext    = 1'b0;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      grant   <= '0;
      mux_sel <= 2'd0;
      reg_we  <= 1'b0;
    end else begin
      state   <= stateNext;
      cnt     <= cntNext;
      grant   <= grantNext;
      mux_sel <= selNext;
      reg_we  <= weNext;
    end
  end

  assign ack   = lastCycle ? grant : 4'b0000;
  assign stall = |(req & ~grant);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed bench for regfile_wb_arbiter with
// one instance at WB_CYCLES=1 and one at WB_CYCLES=3.
module tb_regfile_wb_arbiter;

  logic       clk;
  logic       rst1, rst3;
  logic [3:0] req1, req3;
  logic [1:0] sel1, sel3;
  logic [3:0] gnt1, gnt3;
  logic       we1, we3;
  logic [3:0] ack1, ack3;
  logic       st1, st3;

  int total = 0;
  int bad   = 0;

  logic [3:0] seq [5];

  regfile_wb_arbiter #(.WB_CYCLES(1), .CNT_W(4)) u1 (
    .clk(clk), .rst_n(rst1), .req(req1), .mux_sel(sel1),
    .grant(gnt1), .reg_we(we1), .ack(ack1), .stall(st1)
  );

  regfile_wb_arbiter #(.WB_CYCLES(3), .CNT_W(4)) u3 (
    .clk(clk), .rst_n(rst3), .req(req3), .mux_sel(sel3),
    .grant(gnt3), .reg_we(we3), .ack(ack3), .stall(st3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic reset1;
    rst1 = 1'b0;
    tick;
    rst1 = 1'b1;
  endtask

  initial begin
    rst1 = 1'b0; rst3 = 1'b0;
    req1 = 4'b1111; req3 = 4'b0000;
    tick; tick;
    chk("t1_grant", gnt1, 4'b0000);
    chk("t1_we", we1, 1'b0);
    chk("t1_ack", ack1, 4'b0000);
    chk("t1_sel", sel1, 2'd0);
    chk("t1_stall", st1, 1'b1);
    chk("t1_we3", we3, 1'b0);

    rst1 = 1'b1; rst3 = 1'b1;
    req1 = 4'b0000;
    tick;

    // single write
    req1 = 4'b0010;
    #1;
    chk("t2_stall_pre", st1, 1'b1);
    tick;
    chk("t2_grant", gnt1, 4'b0010);
    chk("t2_sel", sel1, 2'd1);
    chk("t2_we", we1, 1'b1);
    chk("t2_ack", ack1, 4'b0010);
    chk("t2_stall", st1, 1'b0);
    req1 = 4'b0000;
    tick;
    chk("t2_we_off", we1, 1'b0);
    chk("t2_grant_off", gnt1, 4'b0000);

    // contention
    reset1;
    req1 = 4'b1010;
    tick;
    chk("t3_grant_a", gnt1, 4'b0010);
    chk("t3_ack_a", ack1, 4'b0010);
    chk("t3_stall_a", st1, 1'b1);
    req1 = 4'b1000;
    tick;
    chk("t3_grant_b", gnt1, 4'b1000);
    chk("t3_sel_b", sel1, 2'd3);
    chk("t3_we_b", we1, 1'b1);
    chk("t3_stall_b", st1, 1'b0);
    req1 = 4'b0000;
    tick;
    chk("t3_we_off", we1, 1'b0);

    // sustained full request; each owner drops for one cycle after ack
    reset1;
`ifdef WB_RR_EN
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`else
    seq = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001};
`endif
    req1 = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk($sformatf("t5_grant%0d", i), gnt1, seq[i]);
      chk($sformatf("t5_ack%0d", i), ack1, seq[i]);
      req1 = 4'b1111 & ~seq[i];
    end
    req1 = 4'b0000;
    tick;
    chk("t5_we_off", we1, 1'b0);

    // multi-cycle write
    req3 = 4'b0001;
    tick;
    chk("t4_grant", gnt3, 4'b0001);
    chk("t4_sel", sel3, 2'd0);
    chk("t4_we1", we3, 1'b1);
    chk("t4_ack1", ack3, 4'b0000);
    tick;
    chk("t4_we2", we3, 1'b1);
    chk("t4_ack2", ack3, 4'b0000);
    tick;
    chk("t4_we3", we3, 1'b1);
    chk("t4_ack3", ack3, 4'b0001);
    req3 = 4'b0000;
    tick;
    chk("t4_we_off", we3, 1'b0);
    chk("t4_ack_off", ack3, 4'b0000);

    // early drop must not revoke the grant
    req3 = 4'b0100;
    tick;
    chk("ed_grant1", gnt3, 4'b0100);
    req3 = 4'b0000;
    tick;
    chk("ed_grant2", gnt3, 4'b0100);
    tick;
    chk("ed_ack", ack3, 4'b0100);
    tick;
    chk("ed_we_off", we3, 1'b0);

    // back-to-back multi-cycle, no bubble
    req3 = 4'b0011;
    tick; tick; tick;
    chk("bb_ack_a", ack3, 4'b0001);
    req3 = 4'b0010;
    tick;
    chk("bb_grant_b", gnt3, 4'b0010);
    chk("bb_we_b", we3, 1'b1);
    chk("bb_sel_b", sel3, 2'd1);
    tick; tick;
    chk("bb_ack_b", ack3, 4'b0010);
    req3 = 4'b0000;
    tick;

    // reset in the second write cycle
    req3 = 4'b0010;
    tick; tick;
    chk("t6_ack_mid", ack3, 4'b0000);
    chk("t6_we_mid", we3, 1'b1);
    rst3 = 1'b0;
    tick;
    chk("t6_we", we3, 1'b0);
    chk("t6_grant", gnt3, 4'b0000);
    chk("t6_ack", ack3, 4'b0000);
    chk("t6_sel", sel3, 2'd0);
    rst3 = 1'b1;
    req3 = 4'b0000;
    tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
